mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single unified instruction/data memory of the multi-cycle RISC-V core between two requesters: the core (fetch and load/store) and a DMA/loader port. Sits between the core's datapath memory interface and the memory macro. Sequences each access through a fixed-latency memory, and returns a completion pulse plus read data to the winning requester. Arbitration is round-robin or fixed-priority depending on configuration.

## Interface
- `AW`, 32: address width.
- `DW`, 32: data width.
- `LAT`, 2: memory read latency in cycles, counted from the `mem_en` cycle; legal range is ≥ 1.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `core_req`  in  1  core access request; held until `core_gnt`.
- `core_we`  in  1  1 = write, 0 = read.
- `core_addr`  in  AW  core address.
- `core_wdata`  in  DW  core write data.
- `core_gnt`  out  1  one-cycle grant pulse.
- `core_done`  out  1  one-cycle completion pulse.
- `core_rdata`  out  DW  read data; valid when `core_done` is 1; held afterwards.
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_gnt`, `dma_done`, `dma_rdata`: same as the core signals, for the DMA port.
- `mem_en`  out  1  memory access strobe, one cycle.
- `mem_we`  out  1  memory write enable; qualified by `mem_en`.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_rdata`  in  DW  memory read data; valid `LAT` cycles after the `mem_en` cycle.
- `busy`  out  1  1 in any state other than IDLE.

## Operation
- FSM states:
  - IDLE → ACCESS when `core_req | dma_req` is sampled high at a clock edge.
  - ACCESS → WAIT after 1 cycle.
  - WAIT → DONE after `LAT` cycles.
  - DONE → IDLE after 1 cycle.
- On the IDLE→ACCESS edge:
  - select the winner;
  - register `owner`, and register `we`/`addr`/`wdata` from the winner into `mem_we`/`mem_addr`/`mem_wdata`;
  - update `last_owner`.
- ACCESS: `mem_en` = 1 and the winner's `gnt` = 1. All other gnt/en outputs are 0.
- WAIT: a down-counter is loaded with `LAT` on entry. On the last WAIT edge (counter = 1), `mem_rdata` is captured into the owner's `rdata` register, for reads only. For writes, `rdata` is unchanged.
- DONE: the owner's `done` = 1.
- Requests are sampled only in IDLE. A request asserted during ACCESS/WAIT/DONE waits; the losing requester keeps `req` high and is served in the next IDLE cycle.
- Requester inputs `we`/`addr`/`wdata` must be stable while `req` = 1 and before `gnt`. They are ignored after the IDLE edge.
- `mem_addr`/`mem_we`/`mem_wdata` hold their registered values outside ACCESS. `mem_en` = 0 outside ACCESS.
- Reset (async, `rst` = 0):
  - state = IDLE, counter = 0, `last_owner` = DMA (so the core wins the first tie);
  - every output = 0, including `rdata` and `mem_*`, and `busy` = 0.
- Reset mid-transaction aborts it: `mem_en` drops immediately and no `done` is issued.

## Timing
- A request sampled at edge T gives:
  - `gnt` and `mem_en` in cycle T+1;
  - WAIT in cycles T+2 … T+1+`LAT`;
  - `done` plus valid `rdata` in cycle T+2+`LAT`;
  - IDLE in cycle T+3+`LAT`.
- Request-to-done latency is `LAT`+2 cycles. Minimum issue interval is `LAT`+3 cycles.
- Back-to-back requests from one requester: `req` held continuously is re-sampled in the IDLE cycle after DONE. Each access produces exactly one `gnt` and one `done`.
- `done` never coincides with `gnt`. At most one requester's `gnt`/`done` is high in any cycle.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - when both `req` are high in IDLE, grant the requester that is not `last_owner`;
  - when only one is high, grant it.
- `ARB_ROUND_ROBIN_EN` undefined:
  - the core always wins ties (fixed priority);
  - `last_owner` is still maintained but unused.

## Test plan
- Single core read, `LAT`=2, memory word 0x40 = 0xDEADBEEF:
  - `core_req` at edge 0 → `core_gnt`/`mem_en` with `mem_addr`=0x40 in cycle 1;
  - `core_done` with `core_rdata`=0xDEADBEEF in cycle 4;
  - `busy` low in cycle 5.
- DMA write of 0x12345678 to 0x80 → `mem_we`=1, `mem_wdata`=0x12345678 in the `mem_en` cycle; `dma_done` 4 cycles after the request edge; `dma_rdata` unchanged.
- Both `req` held continuously, 4 accesses:
  - with `ARB_ROUND_ROBIN_EN`, grant order is core, DMA, core, DMA;
  - without it, the core gets all 4 and DMA starves.
- Request raised during WAIT → not granted until the IDLE cycle after DONE; exactly one `gnt`.
- `rst` asserted in WAIT → `mem_en`, `busy` and every done output are 0 immediately. After release, a new core request completes normally with no stale `done`.
- `LAT`=1 and `LAT`=4 builds → `done` exactly `LAT`+2 cycles after the request edge, with correct data.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory between the core and a
// DMA/loader port. Each access walks IDLE -> ACCESS -> WAIT (LAT cycles) -> DONE.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin tie-breaking;
// leave it undefined for fixed priority with the core winning every tie.
`timescale 1ns/1ps

module mem_port_arbiter #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    // core requester
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          core_done,
    output logic [DW-1:0] core_rdata,
    // DMA / loader requester
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_done,
    output logic [DW-1:0] dma_rdata,
    // memory macro
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int CW = $clog2(LAT + 1);

    // owner / last_owner encoding: 0 = core, 1 = DMA
    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_DMA  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_owner;
    logic          r_last_owner;
    logic [CW-1:0] r_cnt;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [DW-1:0] r_core_rdata;
    logic [DW-1:0] r_dma_rdata;

    logic          w_start;
    logic          w_pick_dma;
    logic          w_last_wait;

    // A new access starts only from IDLE; requests elsewhere simply wait.
    assign w_start     = (r_state == S_IDLE) && (core_req || dma_req);
    assign w_last_wait = (r_state == S_WAIT) && (r_cnt == CW'(1));

`ifdef ARB_ROUND_ROBIN_EN
    // Round robin: on a tie the port that did not win last time goes next.
    assign w_pick_dma = dma_req && (!core_req || (r_last_owner == OWN_CORE));
`else
    // Fixed priority: DMA only wins when the core is not asking.
    assign w_pick_dma = dma_req && !core_req;

    // last_owner is kept up to date so both builds share state, but only
    // the round-robin build looks at it.
    logic w_unused_last_owner;
    assign w_unused_last_owner = r_last_owner;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_next = S_ACCESS;
            S_ACCESS: w_next = S_WAIT;
            S_WAIT:   if (w_last_wait) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Outputs decoded from state and the registered owner.
    always_comb begin
        mem_en    = 1'b0;
        core_gnt  = 1'b0;
        dma_gnt   = 1'b0;
        core_done = 1'b0;
        dma_done  = 1'b0;
        busy      = (r_state != S_IDLE);
        case (r_state)
            S_ACCESS: begin
                mem_en   = 1'b1;
                core_gnt = (r_owner == OWN_CORE);
                dma_gnt  = (r_owner == OWN_DMA);
            end
            S_DONE: begin
                core_done = (r_owner == OWN_CORE);
                dma_done  = (r_owner == OWN_DMA);
            end
            default: ;
        endcase
    end

    // WAIT down-counter: loaded with LAT on entry, leaves WAIT when it hits 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (r_state == S_ACCESS) begin
            r_cnt <= CW'(LAT);
        end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // Latch the winner's command at the IDLE edge; held for the whole access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner      <= OWN_CORE;
            r_last_owner <= OWN_DMA;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else if (w_start) begin
            r_owner      <= w_pick_dma;
            r_last_owner <= w_pick_dma;
            r_mem_we     <= w_pick_dma ? dma_we    : core_we;
            r_mem_addr   <= w_pick_dma ? dma_addr  : core_addr;
            r_mem_wdata  <= w_pick_dma ? dma_wdata : core_wdata;
        end
    end

    // Read data lands on the last WAIT edge; writes leave rdata untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_core_rdata <= '0;
            r_dma_rdata  <= '0;
        end else if (w_last_wait && !r_mem_we) begin
            if (r_owner == OWN_DMA) begin
                r_dma_rdata <= mem_rdata;
            end else begin
                r_core_rdata <= mem_rdata;
            end
        end
    end

    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign core_rdata = r_core_rdata;
    assign dma_rdata  = r_dma_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus pushes expected grant/done events and
// state probes into queues; a negedge monitor pops and compares them.
`timescale 1ns/1ps

module tb_mem_port_arbiter;
    parameter int LAT = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int P  = LAT + 3;   // issue interval

    // event signature: {mem_en, core_gnt, dma_gnt, core_done, dma_done}
    localparam logic [4:0] CG = 5'b11000;
    localparam logic [4:0] DG = 5'b10100;
    localparam logic [4:0] CD = 5'b00010;
    localparam logic [4:0] DD = 5'b00001;

    logic clk = 1'b0;
    logic rst;
    logic core_req, core_we, core_gnt, core_done;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata, core_rdata;
    logic dma_req, dma_we, dma_gnt, dma_done;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata, dma_rdata;
    logic mem_en, mem_we, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_gnt(core_gnt), .core_done(core_done),
        .core_rdata(core_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_done(dma_done),
        .dma_rdata(dma_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Fixed-latency memory: data is valid only in the cycle LAT after mem_en.
    logic [DW-1:0] mem [64];
    bit   [63:0]   wv;
    bit   [LAT-1:0] pv;
    logic [DW-1:0] pd [LAT];

    function automatic logic [DW-1:0] rd(logic [AW-1:0] a);
        if (wv[a[7:2]]) return mem[a[7:2]];
        if (a == 32'h40) return 32'hDEADBEEF;
        return {16'hC0DE, a[15:0]};
    endfunction

    always @(posedge clk) begin
        for (int k = LAT - 1; k > 0; k--) begin
            pv[k] <= pv[k-1];
            pd[k] <= pd[k-1];
        end
        pv[0] <= mem_en && !mem_we;
        pd[0] <= rd(mem_addr);
        if (mem_en && mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
            wv[mem_addr[7:2]]  <= 1'b1;
        end
    end

    assign mem_rdata = pv[LAT-1] ? pd[LAT-1] : 32'hBAD0BAD0;

    // Scoreboard
    typedef struct {
        int            cyc;
        logic [4:0]    sig;
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] data;
    } ev_t;
    typedef struct {
        int   cyc;
        bit   zero;
        logic busy;
    } pr_t;

    ev_t evq[$];
    pr_t prq[$];
    int checks = 0;
    int errors = 0;

    task automatic cmp(string nm, logic [159:0] act, logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [4:0] obs;
        ev_t e;
        pr_t p;
        obs = {mem_en, core_gnt, dma_gnt, core_done, dma_done};
        while (evq.size() > 0 && evq[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_event at cycle %0d: got nothing, expected sig %b due in cycle %0d",
                     cyc, evq[0].sig, evq[0].cyc);
            void'(evq.pop_front());
        end
        if (obs != 5'b0) begin
            if (evq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output at cycle %0d: got sig %b, expected none", cyc, obs);
            end else begin
                e = evq.pop_front();
                cmp("event_cycle", 160'(cyc), 160'(e.cyc));
                cmp("event_sig", 160'(obs), 160'(e.sig));
                if (e.sig[4]) begin
                    cmp("mem_addr", 160'(mem_addr), 160'(e.addr));
                    cmp("mem_we", 160'(mem_we), 160'(e.we));
                    if (e.we) cmp("mem_wdata", 160'(mem_wdata), 160'(e.data));
                end else begin
                    cmp(e.sig[1] ? "core_rdata" : "dma_rdata",
                        160'(e.sig[1] ? core_rdata : dma_rdata), 160'(e.data));
                end
            end
        end
        while (prq.size() > 0 && prq[0].cyc <= cyc) begin
            p = prq.pop_front();
            if (p.cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_probe at cycle %0d: got none, expected probe of cycle %0d", cyc, p.cyc);
            end else if (p.zero) begin
                cmp("reset_outputs",
                    160'({core_gnt, core_done, core_rdata, dma_gnt, dma_done, dma_rdata,
                          mem_en, mem_we, mem_addr, mem_wdata, busy}), 160'(0));
            end else begin
                cmp("busy", 160'(busy), 160'(p.busy));
            end
        end
    end

    // Stimulus helpers; all drives happen 1 time unit after a rising edge.
    task automatic at_cycle(int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic single(bit dma, bit we, logic [AW-1:0] a, logic [DW-1:0] wd,
                          logic [DW-1:0] rdexp);
        int t;
        t = cyc;
        if (dma) begin
            dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = wd;
        end else begin
            core_req = 1'b1; core_we = we; core_addr = a; core_wdata = wd;
        end
        evq.push_back('{t + 1, dma ? DG : CG, a, we, wd});
        evq.push_back('{t + 2 + LAT, dma ? DD : CD, '0, 1'b0, rdexp});
        prq.push_back('{t + 2 + LAT, 1'b0, 1'b1});
        prq.push_back('{t + 3 + LAT, 1'b0, 1'b0});
        at_cycle(t + 1);
        core_req = 1'b0;
        dma_req  = 1'b0;
        at_cycle(t + 3 + LAT);
    endtask

    initial begin
        int t;
        core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
        dma_req  = 0; dma_we  = 0; dma_addr  = '0; dma_wdata  = '0;
        rst = 1'b1;
        #2 rst = 1'b0;
        prq.push_back('{2, 1'b1, 1'b0});
        at_cycle(3);
        rst = 1'b1;
        at_cycle(5);

        // single accesses
        single(1'b0, 1'b0, 32'h40, '0, 32'hDEADBEEF);          // core read
        single(1'b1, 1'b1, 32'h80, 32'h12345678, 32'h0);       // DMA write, rdata stays 0
        single(1'b0, 1'b0, 32'h80, '0, 32'h12345678);          // core reads DMA's write
        single(1'b1, 1'b0, 32'h44, '0, 32'hC0DE0044);          // DMA read

        // both requesters held for four accesses
        t = cyc;
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h100;
        dma_req  = 1'b1; dma_we  = 1'b0; dma_addr  = 32'h104;
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (i % 2 == 1) begin
                evq.push_back('{t + 1 + i * P, DG, 32'h104, 1'b0, '0});
                evq.push_back('{t + 2 + LAT + i * P, DD, '0, 1'b0, 32'hC0DE0104});
            end else begin
                evq.push_back('{t + 1 + i * P, CG, 32'h100, 1'b0, '0});
                evq.push_back('{t + 2 + LAT + i * P, CD, '0, 1'b0, 32'hC0DE0100});
            end
`else
            evq.push_back('{t + 1 + i * P, CG, 32'h100, 1'b0, '0});
            evq.push_back('{t + 2 + LAT + i * P, CD, '0, 1'b0, 32'hC0DE0100});
`endif
        end
        at_cycle(t + 1 + 3 * P);
        core_req = 1'b0;
        dma_req  = 1'b0;
        at_cycle(t + 3 * P + LAT + 3);

        // DMA request raised during WAIT of a core write
        t = cyc;
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h48; core_wdata = 32'hCAFEF00D;
        evq.push_back('{t + 1, CG, 32'h48, 1'b1, 32'hCAFEF00D});
        evq.push_back('{t + 2 + LAT, CD, '0, 1'b0, 32'hC0DE0100});
        at_cycle(t + 1);
        core_req = 1'b0;
        at_cycle(t + 2);
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h48;
        evq.push_back('{t + 1 + P, DG, 32'h48, 1'b0, '0});
        evq.push_back('{t + 2 + LAT + P, DD, '0, 1'b0, 32'hCAFEF00D});
        at_cycle(t + 1 + P);
        dma_req = 1'b0;
        at_cycle(t + 3 + LAT + P);

        // reset during WAIT aborts the access
        t = cyc;
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h40;
        evq.push_back('{t + 1, CG, 32'h40, 1'b0, '0});
        at_cycle(t + 1);
        core_req = 1'b0;
        at_cycle(t + 2);
        rst = 1'b0;
        prq.push_back('{t + 2, 1'b1, 1'b0});
        at_cycle(t + 4);
        rst = 1'b1;
        at_cycle(t + 5);
        single(1'b0, 1'b0, 32'h40, '0, 32'hDEADBEEF);

        at_cycle(cyc + 3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

endmodule
